// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline hazard inputs in, stall/flush/freeze controls and status out.
// master = pipeline side driving the hazard inputs, slave = the hazard controller.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             IDEX_MemRead;
  logic [4:0]       IDEX_RD;
  logic [4:0]       IFID_RS1;
  logic [4:0]       IFID_RS2;
  logic             branch_taken;
  logic             mem_busy;
  logic             PCWrite;
  logic             IFID_Write;
  logic             IFID_Flush;
  logic             IDEX_Flush;
  logic             EXMEM_Flush;
  logic             Freeze;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output IDEX_MemRead, IDEX_RD, IFID_RS1, IFID_RS2, branch_taken, mem_busy,
    input  PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, Freeze,
    input  mem_timeout, stall_cycles, flush_events
  );

  modport slave (
    input  IDEX_MemRead, IDEX_RD, IFID_RS1, IFID_RS2, branch_taken, mem_busy,
    output PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, Freeze,
    output mem_timeout, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch-redirect flushes, memory-busy freeze, watchdog, perf counters.
// Controls are combinational from state+inputs (same-cycle); no backpressure, mem_busy freezes the pipe.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int BW  = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    MEMWAIT = 2'd2
  } state_e;

  state_e           state_q, state_d, eff_state;
  logic [FCW-1:0]   flush_cnt_q, flush_cnt_d;
  logic             pend_q, pend_d;
  logic [BW-1:0]    busy_cnt_q, busy_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] fev_q, fev_d;

  logic load_use;
  logic redirect;
  logic pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, freeze;

  assign load_use = hz.IDEX_MemRead && (hz.IDEX_RD != 5'd0) &&
                    ((hz.IDEX_RD == hz.IFID_RS1) || (hz.IDEX_RD == hz.IFID_RS2));
  assign redirect = hz.branch_taken || pend_q;

  // The cycle memory releases behaves like the state being resumed (RUN, or FLUSH if interrupted mid-flush).
  always_comb begin
    eff_state = state_q;
    if (state_q == MEMWAIT && !hz.mem_busy) begin
      eff_state = (flush_cnt_q != '0) ? FLUSH : RUN;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      pend_q      <= 1'b0;
      busy_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_q     <= '0;
      fev_q       <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      pend_q      <= pend_d;
      busy_cnt_q  <= busy_cnt_d;
      timeout_q   <= timeout_d;
      stall_q     <= stall_d;
      fev_q       <= fev_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pend_d      = pend_q;
    busy_cnt_d  = '0;
    timeout_d   = timeout_q;
    fev_d       = fev_q;
    stall_d     = stall_q;

    if (hz.mem_busy) begin
      state_d    = MEMWAIT;
      pend_d     = pend_q || hz.branch_taken;
      busy_cnt_d = (busy_cnt_q == BW'(MEM_TIMEOUT)) ? busy_cnt_q : busy_cnt_q + 1'b1;
      if (busy_cnt_d == BW'(MEM_TIMEOUT)) begin
        timeout_d = 1'b1;
      end
    end else if (redirect) begin
      pend_d = 1'b0;
      if (fev_q != '1) begin
        fev_d = fev_q + 1'b1;
      end
      if (FLUSH_CYCLES > 1) begin
        state_d     = FLUSH;
        flush_cnt_d = FCW'(FLUSH_CYCLES - 1);
      end else begin
        state_d     = RUN;
        flush_cnt_d = '0;
      end
    end else if (eff_state == FLUSH) begin
      flush_cnt_d = flush_cnt_q - 1'b1;
      state_d     = (flush_cnt_q == FCW'(1)) ? RUN : FLUSH;
    end else begin
      state_d = RUN;
    end

    if (!pc_write && stall_q != '1) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // Output logic
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    freeze      = 1'b0;
    if (hz.mem_busy) begin
      freeze     = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (redirect) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (eff_state == FLUSH) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign hz.PCWrite      = pc_write;
  assign hz.IFID_Write   = ifid_write;
  assign hz.IFID_Flush   = ifid_flush;
  assign hz.IDEX_Flush   = idex_flush;
  assign hz.EXMEM_Flush  = exmem_flush;
  assign hz.Freeze       = freeze;
  assign hz.mem_timeout  = timeout_q;
  assign hz.stall_cycles = stall_q;
  assign hz.flush_events = fev_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=4) with an expected-result queue.
module tb_hazard_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  hazard_ctrl_if #(.CNT_W(32)) hz ();

  hazard_ctrl #(
    .FLUSH_CYCLES(2),
    .MEM_TIMEOUT (4),
    .CNT_W       (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz.slave)
  );

  typedef struct packed {
    logic [5:0]  ctrl;
    logic        to;
    logic [31:0] st;
    logic [31:0] fe;
  } exp_t;

  exp_t sb[$];

  // Control vector order: {PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, Freeze}
  localparam logic [5:0] DEF = 6'b110000;
  localparam logic [5:0] LU  = 6'b000100;
  localparam logic [5:0] RDR = 6'b111110;
  localparam logic [5:0] FL  = 6'b111100;
  localparam logic [5:0] FRZ = 6'b000001;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic mr, input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                      input logic bt, input logic mb, input logic [5:0] ec, input logic eto,
                      input int est, input int efe, input string tag);
    exp_t e;
    exp_t g;
    hz.IDEX_MemRead = mr;
    hz.IDEX_RD      = rd;
    hz.IFID_RS1     = r1;
    hz.IFID_RS2     = r2;
    hz.branch_taken = bt;
    hz.mem_busy     = mb;
    e.ctrl = ec;
    e.to   = eto;
    e.st   = 32'(est);
    e.fe   = 32'(efe);
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    chk({tag, "/ctrl"}, 32'({hz.PCWrite, hz.IFID_Write, hz.IFID_Flush, hz.IDEX_Flush,
                              hz.EXMEM_Flush, hz.Freeze}), 32'(g.ctrl));
    chk({tag, "/timeout"}, 32'(hz.mem_timeout), 32'(g.to));
    chk({tag, "/stall_cycles"}, hz.stall_cycles, g.st);
    chk({tag, "/flush_events"}, hz.flush_events, g.fe);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [5:0] ec, input logic eto, input int est, input int efe, input string tag);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ec, eto, est, efe, tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    hz.IDEX_MemRead = 1'b0;
    hz.IDEX_RD      = 5'd0;
    hz.IFID_RS1     = 5'd0;
    hz.IFID_RS2     = 5'd0;
    hz.branch_taken = 1'b0;
    hz.mem_busy     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle(DEF, 1'b0, 0, 0, "reset_state");
    reset = 1'b0;
    idle(DEF, 1'b0, 0, 0, "idle0");

    // load-use on RS1, then RD=0 ignored, then RS2 match, then non-load
    step(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, LU,  1'b0, 0, 0, "lu_rs1");
    idle(DEF, 1'b0, 1, 0, "after_lu");
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, DEF, 1'b0, 1, 0, "rd_zero");
    step(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, LU,  1'b0, 1, 0, "lu_rs2");
    step(1'b0, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, DEF, 1'b0, 2, 0, "no_load");

    // two-cycle redirect flush
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, RDR, 1'b0, 2, 0, "redirect_c0");
    idle(FL,  1'b0, 2, 1, "redirect_c1");
    idle(DEF, 1'b0, 2, 1, "redirect_done");

    // branch during memory wait is held and applied on release
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, FRZ, 1'b0, 2, 1, "busy_c0");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, FRZ, 1'b0, 3, 1, "busy_c1_bt");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, FRZ, 1'b0, 4, 1, "busy_c2");
    idle(RDR, 1'b0, 5, 1, "pend_redirect");
    idle(FL,  1'b0, 5, 2, "pend_flush2");
    idle(DEF, 1'b0, 5, 2, "pend_done");

    // watchdog: six busy cycles, timeout after the fourth, sticky
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, FRZ, (i >= 4) ? 1'b1 : 1'b0, 5 + i, 2, "wd_busy");
    end
    idle(DEF, 1'b1, 11, 2, "wd_release");
    idle(DEF, 1'b1, 11, 2, "wd_sticky");

    // memory busy interrupting a flush: resumes the remaining flush cycle
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, RDR, 1'b1, 11, 2, "fl_start");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, FRZ, 1'b1, 11, 3, "fl_busy");
    idle(FL,  1'b1, 12, 3, "fl_resume");
    idle(DEF, 1'b1, 12, 3, "fl_done");

    // load-use with branch: redirect wins; new branch inside FLUSH restarts; FLUSH beats load-use
    step(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, RDR, 1'b1, 12, 3, "lu_bt");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, RDR, 1'b1, 12, 4, "restart_bt");
    step(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, FL,  1'b1, 12, 5, "flush_over_lu");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, RDR, 1'b1, 12, 5, "bt_again");

    // reset while in FLUSH
    reset = 1'b1;
    idle(FL,  1'b1, 12, 6, "rst_in_flush");
    reset = 1'b0;
    idle(DEF, 1'b0, 0, 0, "after_rst_flush");

    // reset while in MEMWAIT with a pending redirect drops the pending branch
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, FRZ, 1'b0, 0, 0, "mw_pend");
    reset = 1'b1;
    idle(RDR, 1'b0, 1, 0, "rst_in_memwait");
    reset = 1'b0;
    idle(DEF, 1'b0, 0, 0, "after_rst_mw");
    idle(DEF, 1'b0, 0, 0, "pend_dropped");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
